// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage: PC register, instruction-memory request/response handshake,
// small fetch queue and IF/ID pipeline register feeding decode.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_stall_pc, i_stall_IF            hazard-unit stalls (PC / IF-ID register)
//   i_flush_IF, i_br_target           branch redirect and its target
//   o_imem_req_vld, o_imem_addr       fetch request (combinational)
//   i_imem_req_rdy                    memory accepts request
//   i_imem_rsp_vld, i_imem_rsp_data   in-order fetch response
//   o_instr_ID, o_pc_ID, o_valid_ID   IF/ID register contents
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall_pc,
   input  logic        i_stall_IF,
   input  logic        i_flush_IF,
   input  logic [31:0] i_br_target,
   output logic        o_imem_req_vld,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_req_rdy,
   input  logic        i_imem_rsp_vld,
   input  logic [31:0] i_imem_rsp_data,
   output logic [31:0] o_instr_ID,
   output logic [31:0] o_pc_ID,
   output logic        o_valid_ID
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fq_entry_t;

   logic [31:0]      pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] q_count;
   logic [PTR_W-1:0] q_head, q_tail;
   logic [PTR_W-1:0] pcf_head, pcf_tail;
   fq_entry_t        q_mem [FIFO_DEPTH];
   logic [31:0]      pcf_mem [FIFO_DEPTH];
   fq_entry_t        q_head_entry;
   logic [31:0]      rsp_pc;

   logic credit_ok, accept, rsp_ok, rsp_keep, id_load, q_empty, q_pop, q_push, bypass;
   logic unused_tgt_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign unused_tgt_bits = ^i_br_target[1:0];

   // Handshake and queue control; requests are credit-limited so the queue never overflows
   always_comb begin
      credit_ok       = (SUM_W'(outstanding) + SUM_W'(q_count)) < SUM_W'(FIFO_DEPTH);
      o_imem_req_vld  = i_rst_n & ~i_stall_pc & ~i_flush_IF & credit_ok;
      o_imem_addr     = pc;
      accept          = o_imem_req_vld & i_imem_req_rdy;
      // A response with nothing outstanding is a protocol error and is ignored
      rsp_ok          = i_imem_rsp_vld & (outstanding != '0);
      rsp_keep        = rsp_ok & (drop_cnt == '0) & ~i_flush_IF;
      id_load         = ~i_flush_IF & ~i_stall_IF;
      q_empty         = (q_count == '0);
      q_pop           = id_load & ~q_empty;
      bypass          = id_load & q_empty & rsp_keep;
      q_push          = rsp_keep & ~bypass;
      outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
      q_head_entry    = q_mem[q_head];
      rsp_pc          = pcf_mem[pcf_head];
   end

   // PC, credit counters and pointers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc          <= RESET_PC_AL;
         outstanding <= '0;
         drop_cnt    <= '0;
         pcf_head    <= '0;
         pcf_tail    <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         q_count     <= '0;
      end else begin
         if (i_flush_IF)  pc <= {i_br_target[31:2], 2'b00};
         else if (accept) pc <= pc + 32'd4;

         outstanding <= outstanding_nxt;

         // Everything still in flight after a flush belongs to the wrong path
         if (i_flush_IF)                     drop_cnt <= outstanding_nxt;
         else if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);

         // Return-order PC FIFO: one entry per outstanding request, dropped or not
         if (accept) pcf_tail <= ptr_inc(pcf_tail);
         if (rsp_ok) pcf_head <= ptr_inc(pcf_head);

         if (i_flush_IF) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
         end else begin
            if (q_push) q_tail <= ptr_inc(q_tail);
            if (q_pop)  q_head <= ptr_inc(q_head);
            q_count <= q_count + CNT_W'(q_push) - CNT_W'(q_pop);
         end
      end
   end

   // Storage arrays (contents qualified by pointers/counts, no reset needed)
   always_ff @(posedge i_clk) begin
      if (accept) pcf_mem[pcf_tail] <= pc;
      if (q_push) q_mem[q_tail]     <= {i_imem_rsp_data, rsp_pc};
   end

   // IF/ID register: flush > stall > queue head > bypassed response > bubble
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid_ID <= 1'b0;
         o_instr_ID <= NOP_INSTR;
         o_pc_ID    <= '0;
      end else if (i_flush_IF) begin
         o_valid_ID <= 1'b0;
         o_instr_ID <= NOP_INSTR;
      end else if (!i_stall_IF) begin
         if (q_pop) begin
            o_valid_ID <= 1'b1;
            o_instr_ID <= q_head_entry.instr;
            o_pc_ID    <= q_head_entry.pc;
         end else if (bypass) begin
            o_valid_ID <= 1'b1;
            o_instr_ID <= i_imem_rsp_data;
            o_pc_ID    <= rsp_pc;
         end else begin
            o_valid_ID <= 1'b0;
            o_instr_ID <= NOP_INSTR;
         end
      end
   end

endmodule
